// File: rtl/gcd_pkg.sv
// Shared definitions for the subtractive GCD controller.
//   gcd_state_e      : controller FSM state encoding
//   DW_DEFAULT       : default operand/result width (matches the datapath)
//   IW_DEFAULT       : default iteration counter width
//   MAX_ITER_DEFAULT : default subtraction budget before abort
package gcd_pkg;

    localparam int unsigned DW_DEFAULT       = 16;
    localparam int unsigned IW_DEFAULT       = 16;
    localparam int unsigned MAX_ITER_DEFAULT = 65535;

    typedef enum logic [2:0] {
        StIdle,
        StLoadA,
        StLoadB,
        StRun,
        StDone
    } gcd_state_e;

endpackage

// File: rtl/gcd_iter_cnt.sv
// Saturating iteration counter for the GCD controller.
// Ports:
//   clk    in        clock, all state on posedge
//   rst    in        synchronous active-high reset, clears the count
//   clr    in        clear the count (new operation)
//   inc    in        count one subtraction
//   count  out [IW]  subtractions performed so far
//   at_max out       count has reached MAX_ITER; further inc is ignored
module gcd_iter_cnt #(
    parameter int unsigned IW       = 16,
    parameter int unsigned MAX_ITER = 65535
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [IW-1:0] count,
    output logic          at_max
);

    localparam logic [IW-1:0] MaxCnt = IW'(MAX_ITER);

    logic [IW-1:0] count_q;
    logic [IW-1:0] count_d;

    assign at_max = (count_q == MaxCnt);
    assign count  = count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && !at_max) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/gcd_controller.sv
// Control FSM for the subtractive GCD datapath.
// Accepts an operand pair over valid/ready, loads the datapath registers, steps the
// subtract loop using the datapath compare flags, and returns the result over valid/ready
// together with the iteration count and an error flag.
// Ports:
//   clk, rst               clock; synchronous active-high reset
//   req_valid/req_ready    operand handshake (ready only in idle)
//   req_a, req_b   [DW]    operands
//   rsp_valid/rsp_ready    result handshake (valid only in done)
//   rsp_gcd        [DW]    result (0 when rsp_err)
//   rsp_err                both operands zero, or iteration budget exhausted
//   rsp_iters      [IW]    subtractions performed
//   dp_data_in     [DW]    operand driven onto the datapath bus
//   dp_ldA, dp_ldB         datapath register load strobes
//   dp_sel1, dp_sel2       subtractor X/Y mux selects (0=A, 1=B)
//   dp_sel_in              bus mux (1=dp_data_in, 0=subtractor)
//   dp_lt, dp_gt, dp_eq    datapath compare flags, A vs B
//   dp_result      [DW]    datapath register A
module gcd_controller
    import gcd_pkg::*;
#(
    parameter int unsigned DW       = DW_DEFAULT,
    parameter int unsigned IW       = IW_DEFAULT,
    parameter int unsigned MAX_ITER = MAX_ITER_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [DW-1:0] req_a,
    input  logic [DW-1:0] req_b,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_gcd,
    output logic          rsp_err,
    output logic [IW-1:0] rsp_iters,
    output logic [DW-1:0] dp_data_in,
    output logic          dp_ldA,
    output logic          dp_ldB,
    output logic          dp_sel1,
    output logic          dp_sel2,
    output logic          dp_sel_in,
    input  logic          dp_lt,
    input  logic          dp_gt,
    input  logic          dp_eq,
    input  logic [DW-1:0] dp_result
);

    gcd_state_e    state_q, state_d;
    logic [DW-1:0] a_q, b_q;
    logic          err_q, err_d;
    logic          capture;
    logic          cnt_clr;
    logic          cnt_inc;
    logic          at_max;
    logic          a_zero;
    logic          b_zero;
    logic          ld_a_raw;
    logic          ld_b_raw;

    assign a_zero = (a_q == '0);
    assign b_zero = (b_q == '0);

    gcd_iter_cnt #(
        .IW       (IW),
        .MAX_ITER (MAX_ITER)
    ) u_iter_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr),
        .inc    (cnt_inc),
        .count  (rsp_iters),
        .at_max (at_max)
    );

    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        capture    = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        dp_data_in = b_q;
        ld_a_raw   = 1'b0;
        ld_b_raw   = 1'b0;
        dp_sel1    = 1'b0;
        dp_sel2    = 1'b0;
        dp_sel_in  = 1'b0;

        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    capture = 1'b1;
                    cnt_clr = 1'b1;
                    err_d   = 1'b0;
                    state_d = StLoadA;
                end
            end
            StLoadA: begin
                // With a zero operand the other one is the answer, so park it in A.
                dp_sel_in  = 1'b1;
                ld_a_raw   = 1'b1;
                dp_data_in = a_zero ? b_q : a_q;
                if (a_zero || b_zero) begin
                    err_d   = a_zero && b_zero;
                    state_d = StDone;
                end else begin
                    state_d = StLoadB;
                end
            end
            StLoadB: begin
                dp_sel_in  = 1'b1;
                ld_b_raw   = 1'b1;
                dp_data_in = b_q;
                state_d    = StRun;
            end
            StRun: begin
                if (dp_eq) begin
                    state_d = StDone;
                end else if (at_max) begin
                    // Budget spent without converging: abort, no further load.
                    err_d   = 1'b1;
                    state_d = StDone;
                end else if (dp_gt) begin
                    ld_a_raw = 1'b1;
                    dp_sel2  = 1'b1;
                    cnt_inc  = 1'b1;
                end else if (dp_lt) begin
                    ld_b_raw = 1'b1;
                    dp_sel1  = 1'b1;
                    cnt_inc  = 1'b1;
                end
            end
            StDone: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Loads are suppressed during reset so a mid-operation reset cannot corrupt the datapath.
    assign dp_ldA  = ld_a_raw && !rst;
    assign dp_ldB  = ld_b_raw && !rst;

    assign rsp_err = err_q;
    assign rsp_gcd = err_q ? '0 : dp_result;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            err_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (capture) begin
                a_q <= req_a;
                b_q <= req_b;
            end
        end
    end

endmodule
